// File: rtl/watch_pkg.sv
// Shared types for the lap stopwatch: FSM states, BCD digits and the six-digit time word.
package watch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STOP   = 2'd2,
        ST_RECALL = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // MM:SS.CC, most significant minute digit in the top nibble
    typedef struct packed {
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
        bcd_t c1;
        bcd_t c0;
    } time_t;

    localparam bcd_t DIG_MAX9 = 4'd9;
    localparam bcd_t DIG_MAX5 = 4'd5;

    function automatic bcd_t bcd_step(bcd_t d, bcd_t lim, logic en);
        if (!en) begin
            return d;
        end
        return (d == lim) ? 4'd0 : bcd_t'(d + 4'd1);
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Cascaded BCD MM:SS.CC counter; advances one centisecond per inc, wraps 59:59.99 -> 00:00.00.
// Result is registered (visible the cycle after inc); clr wins over inc; wrap is combinational with inc.
module bcd_time_counter
    import watch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  clr,
    output time_t time_bcd,
    output logic  wrap
);

    time_t      t_q;
    time_t      t_d;
    logic [6:0] cy;

    always_comb begin
        cy[0]  = inc;
        cy[1]  = cy[0] && (t_q.c0 == DIG_MAX9);
        cy[2]  = cy[1] && (t_q.c1 == DIG_MAX9);
        cy[3]  = cy[2] && (t_q.s0 == DIG_MAX9);
        cy[4]  = cy[3] && (t_q.s1 == DIG_MAX5);
        cy[5]  = cy[4] && (t_q.m0 == DIG_MAX9);
        cy[6]  = cy[5] && (t_q.m1 == DIG_MAX5);
        t_d.c0 = bcd_step(t_q.c0, DIG_MAX9, cy[0]);
        t_d.c1 = bcd_step(t_q.c1, DIG_MAX9, cy[1]);
        t_d.s0 = bcd_step(t_q.s0, DIG_MAX9, cy[2]);
        t_d.s1 = bcd_step(t_q.s1, DIG_MAX5, cy[3]);
        t_d.m0 = bcd_step(t_q.m0, DIG_MAX9, cy[4]);
        t_d.m1 = bcd_step(t_q.m1, DIG_MAX5, cy[5]);
    end

    assign wrap     = cy[6];
    assign time_bcd = t_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Centisecond stopwatch with lap memory and recall; key events act three edges after a raw key rises.
// Display is registered and shows the live time, or the selected lap while in RECALL.
module lap_stopwatch
    import watch_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TICK_FREQ = 100,
    parameter int LAP_DEPTH = 8
) (
    input  logic                         clk_50Mhz,
    input  logic                         rst_n,
    input  logic                         key_start,
    input  logic                         key_lap,
    input  logic                         key_recall,
    output logic [23:0]                  disp_out,
    output logic [1:0]                   state,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_full,
    output logic                         overflow
);

    localparam int DIV = CLK_FREQ / TICK_FREQ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(LAP_DEPTH);
    localparam int CW  = IW + 1;

    logic [2:0]    key_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    key_prev;
    logic [2:0]    key_rise;
    logic          ev_start;
    logic          ev_lap;
    logic          ev_recall;

    state_t        cur_st;
    state_t        nxt_st;
    logic          run_en;
    logic          lap_wr;
    logic          do_clear;
    logic          idx_rst;
    logic          idx_step;

    logic [PW-1:0] presc;
    logic          tick;
    time_t         cur_time;
    logic          time_wrap;

    time_t         lap_mem [LAP_DEPTH];
    logic [IW-1:0] rec_idx;
    logic [CW-1:0] lap_cnt_q;
    logic          mem_full;
    logic          full_q;
    logic          ovf_q;
    logic [23:0]   disp_q;

    assign key_raw = {key_recall, key_lap, key_start};

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            key_prev <= '0;
        end else begin
            sync1    <= key_raw;
            sync2    <= sync1;
            key_prev <= sync2;
        end
    end

    // Only the highest-priority rising edge in a cycle survives
    assign key_rise  = sync2 & ~key_prev;
    assign ev_start  = key_rise[0];
    assign ev_lap    = key_rise[1] & ~key_rise[0];
    assign ev_recall = key_rise[2] & ~(|key_rise[1:0]);

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            cur_st <= ST_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            ST_IDLE: begin
                if (ev_start) nxt_st = ST_RUN;
            end
            ST_RUN: begin
                if (ev_start) nxt_st = ST_STOP;
            end
            ST_STOP: begin
                if (ev_start)                                nxt_st = ST_RUN;
                else if (ev_lap)                             nxt_st = ST_IDLE;
                else if (ev_recall && (lap_cnt_q != '0))     nxt_st = ST_RECALL;
            end
            ST_RECALL: begin
                if (ev_start)    nxt_st = ST_STOP;
                else if (ev_lap) nxt_st = ST_IDLE;
            end
            default: nxt_st = ST_IDLE;
        endcase
    end

    always_comb begin
        run_en   = 1'b0;
        lap_wr   = 1'b0;
        do_clear = 1'b0;
        idx_rst  = 1'b0;
        idx_step = 1'b0;
        case (cur_st)
            ST_RUN: begin
                run_en = 1'b1;
                lap_wr = ev_lap;
            end
            ST_STOP: begin
                do_clear = ev_lap;
                idx_rst  = ev_recall && (lap_cnt_q != '0);
            end
            ST_RECALL: begin
                do_clear = ev_lap;
                idx_step = ev_recall;
            end
            default: ;
        endcase
    end

    // Prescaler holds outside RUN so a resume keeps the sub-tick phase
    assign tick = run_en && (presc == PW'(DIV - 1));

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n || do_clear) begin
            presc <= '0;
        end else if (run_en) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    bcd_time_counter u_time (
        .clk      (clk_50Mhz),
        .rst_n    (rst_n),
        .inc      (tick),
        .clr      (do_clear),
        .time_bcd (cur_time),
        .wrap     (time_wrap)
    );

    assign mem_full = (lap_cnt_q == CW'(LAP_DEPTH));

    // Captures the pre-increment time when a lap lands on a tick edge
    always_ff @(posedge clk_50Mhz) begin
        if (rst_n && lap_wr && !mem_full) begin
            lap_mem[lap_cnt_q[IW-1:0]] <= cur_time;
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n || do_clear) begin
            lap_cnt_q <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rec_idx   <= '0;
        end else begin
            if (lap_wr) begin
                if (mem_full) full_q    <= 1'b1;
                else          lap_cnt_q <= lap_cnt_q + 1'b1;
            end
            if (time_wrap) ovf_q <= 1'b1;
            if (idx_rst) begin
                rec_idx <= '0;
            end else if (idx_step) begin
                rec_idx <= ({1'b0, rec_idx} == lap_cnt_q - 1'b1) ? '0 : rec_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else begin
            disp_q <= (cur_st == ST_RECALL) ? lap_mem[rec_idx] : cur_time;
        end
    end

    assign disp_out  = disp_q;
    assign state     = cur_st;
    assign lap_count = lap_cnt_q;
    assign lap_full  = full_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: directed scenarios plus randomized keys against an integer-time reference model.
module tb_lap_stopwatch;

    localparam int CLK_FREQ  = 1000;
    localparam int TICK_FREQ = 100;
    localparam int DEPTH     = 8;
    localparam int DIV       = CLK_FREQ / TICK_FREQ;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int MAX_CS    = 360000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_start = 1'b0;
    logic          key_lap = 1'b0;
    logic          key_recall = 1'b0;
    logic [23:0]   disp_out;
    logic [1:0]    state;
    logic [CW-1:0] lap_count;
    logic          lap_full;
    logic          overflow;

    lap_stopwatch #(
        .CLK_FREQ  (CLK_FREQ),
        .TICK_FREQ (TICK_FREQ),
        .LAP_DEPTH (DEPTH)
    ) dut (
        .clk_50Mhz  (clk),
        .rst_n      (rst_n),
        .key_start  (key_start),
        .key_lap    (key_lap),
        .key_recall (key_recall),
        .disp_out   (disp_out),
        .state      (state),
        .lap_count  (lap_count),
        .lap_full   (lap_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: time held as integer centiseconds
    int          m_st;
    int          m_pre;
    int          m_time;
    int          m_cnt;
    int          m_idx;
    bit          m_full;
    bit          m_ovf;
    int          m_laps [DEPTH];
    logic [23:0] m_disp;
    bit   [2:0]  m_k1, m_k2, m_k3;
    bit          preload_on = 1'b0;

    function automatic logic [23:0] to_bcd(int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_clear();
        m_st = 0; m_time = 0; m_cnt = 0; m_full = 0; m_ovf = 0; m_pre = 0; m_idx = 0;
    endtask

    task automatic model_step();
        bit [2:0] ev;
        bit es, el, er;
        int old_time;
        if (!rst_n) begin
            model_clear();
            m_disp = '0;
            m_k1 = '0; m_k2 = '0; m_k3 = '0;
            return;
        end
        ev = m_k2 & ~m_k3;
        m_k3 = m_k2;
        m_k2 = m_k1;
        m_k1 = {key_recall, key_lap, key_start};
        es = ev[0];
        el = ev[1] && !es;
        er = ev[2] && !es && !el;
        if (preload_on) m_time = MAX_CS - 1;
        m_disp = (m_st == 3) ? to_bcd(m_laps[m_idx]) : to_bcd(m_time);
        old_time = m_time;
        if (m_st == 1) begin
            if (m_pre == DIV - 1) begin
                m_pre = 0;
                if (m_time == MAX_CS - 1) m_ovf = 1;
                m_time = (m_time + 1) % MAX_CS;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        case (m_st)
            0: if (es) m_st = 1;
            1: begin
                if (es) m_st = 2;
                else if (el) begin
                    if (m_cnt < DEPTH) begin
                        m_laps[m_cnt] = old_time;
                        m_cnt = m_cnt + 1;
                    end else begin
                        m_full = 1;
                    end
                end
            end
            2: begin
                if (es) m_st = 1;
                else if (el) model_clear();
                else if (er && m_cnt > 0) begin m_st = 3; m_idx = 0; end
            end
            default: begin
                if (es) m_st = 2;
                else if (el) model_clear();
                else if (er) m_idx = (m_idx + 1) % m_cnt;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit l, input bit r);
        key_start = s; key_lap = l; key_recall = r;
        @(negedge clk);
        key_start = 0; key_lap = 0; key_recall = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(3);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (disp_out !== 24'h0) begin errors++; $display("FAIL reset_disp got=%h want=000000", disp_out); end
        checks++; if (lap_count !== '0) begin errors++; $display("FAIL reset_lap_count got=%0d want=0", lap_count); end
        checks++; if (lap_full !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags got full=%b ovf=%b want 0 0", lap_full, overflow);
        end
        rst_n = 1;
        tick(2);
    endtask

    task automatic test_run_stop();
        press(1, 0, 0);
        tick(999);
        press(1, 0, 0);
        tick(3);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL run_stop_state got=%0d want=2", state); end
        checks++; if (disp_out !== 24'h000100) begin errors++; $display("FAIL run_stop_disp got=%h want=000100", disp_out); end
    endtask

    task automatic test_overflow();
        int i;
        press(1, 0, 0);
        tick(3);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL ovf_resume_state got=%0d want=1", state); end
        if (m_pre == DIV - 1) tick(1);
        force dut.u_time.t_q = 24'h595999;
        preload_on = 1;
        tick(1);
        release dut.u_time.t_q;
        preload_on = 0;
        i = 0;
        while (overflow !== 1'b1 && i < 2 * DIV) begin tick(1); i++; end
        checks++; if (overflow !== 1'b1 || i > DIV) begin
            errors++; $display("FAIL ovf_flag got=%b after %0d clocks want=1 within %0d", overflow, i, DIV);
        end
        tick(1);
        checks++; if (disp_out !== 24'h000000) begin errors++; $display("FAIL ovf_wrap_disp got=%h want=000000", disp_out); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL ovf_keeps_run got=%0d want=1", state); end
        tick(DIV);
        checks++; if (disp_out !== 24'h000001) begin errors++; $display("FAIL ovf_continues got=%h want=000001", disp_out); end
        press(1, 0, 0); tick(3);
        press(0, 1, 0); tick(3);
        checks++; if (state !== 2'd0 || overflow !== 1'b0 || disp_out !== 24'h0) begin
            errors++; $display("FAIL stop_clear got st=%0d ovf=%b disp=%h want 0 0 000000", state, overflow, disp_out);
        end
    endtask

    task automatic test_lap_full();
        int t0;
        int i;
        logic [23:0] lap0;
        press(1, 0, 0); tick(3);
        i = 0;
        while (m_pre != DIV - 3 && i < 2 * DIV) begin tick(1); i++; end
        t0 = m_time;
        lap0 = to_bcd(t0);
        for (int n = 0; n < DEPTH; n++) begin
            press(0, 1, 0);
            tick($urandom_range(DIV, 2 * DIV));
        end
        checks++; if (lap_count !== CW'(DEPTH) || lap_full !== 1'b0) begin
            errors++; $display("FAIL laps_at_depth got cnt=%0d full=%b want %0d 0", lap_count, lap_full, DEPTH);
        end
        press(0, 1, 0); tick(3);
        checks++; if (lap_count !== CW'(DEPTH) || lap_full !== 1'b1) begin
            errors++; $display("FAIL lap_dropped got cnt=%0d full=%b want %0d 1", lap_count, lap_full, DEPTH);
        end
        press(1, 0, 0); tick(3);
        press(0, 0, 1); tick(3);
        checks++; if (state !== 2'd3 || disp_out !== lap0) begin
            errors++; $display("FAIL recall_first got st=%0d disp=%h want 3 %h", state, disp_out, lap0);
        end
        for (int n = 0; n < DEPTH; n++) begin
            press(0, 0, 1); tick(3);
            checks++; if (disp_out !== to_bcd(m_laps[m_idx])) begin
                errors++; $display("FAIL recall_step%0d got=%h want=%h", n, disp_out, to_bcd(m_laps[m_idx]));
            end
        end
        checks++; if (disp_out !== lap0 || state !== 2'd3) begin
            errors++; $display("FAIL recall_wrap got st=%0d disp=%h want 3 %h", state, disp_out, lap0);
        end
    endtask

    task automatic test_simultaneous();
        press(0, 1, 0); tick(3);
        checks++; if (state !== 2'd0 || lap_count !== '0 || lap_full !== 1'b0) begin
            errors++; $display("FAIL recall_clear got st=%0d cnt=%0d full=%b want 0 0 0", state, lap_count, lap_full);
        end
        press(1, 0, 0); tick(3);
        press(0, 1, 0); tick(DIV);
        press(0, 1, 0); tick(DIV);
        press(1, 1, 0); tick(3);
        checks++; if (state !== 2'd2 || lap_count !== CW'(2)) begin
            errors++; $display("FAIL start_beats_lap got st=%0d cnt=%0d want 2 2", state, lap_count);
        end
        press(0, 1, 1); tick(3);
        checks++; if (state !== 2'd0 || lap_count !== '0 || disp_out !== 24'h0) begin
            errors++; $display("FAIL lap_beats_recall got st=%0d cnt=%0d disp=%h want 0 0 000000", state, lap_count, disp_out);
        end
    endtask

    task automatic test_phase();
        int i;
        int k;
        logic [23:0] d_stop;
        press(1, 0, 0); tick(3);
        tick(DIV + 2);
        i = 0;
        while (m_pre != 0 && i < 2 * DIV) begin tick(1); i++; end
        press(1, 0, 0); tick(2);
        d_stop = disp_out;
        press(0, 0, 1); tick(47);
        checks++; if (state !== 2'd2 || disp_out !== d_stop) begin
            errors++; $display("FAIL stop_hold got st=%0d disp=%h want 2 %h", state, disp_out, d_stop);
        end
        press(1, 0, 0);
        k = 1;
        while (disp_out === d_stop && k < 30) begin tick(1); k++; end
        checks++; if (k != 11) begin
            errors++; $display("FAIL resume_phase got=%0d clocks want=7", k - 4);
        end
    endtask

    task automatic test_reset_recall();
        press(1, 0, 0); tick(3);
        press(0, 1, 0); tick(3);
        press(1, 0, 0); tick(3);
        for (int n = 0; n < 3; n++) begin press(0, 1, 0); tick(DIV + 2); end
        press(1, 0, 0); tick(3);
        press(0, 0, 1); tick(3);
        checks++; if (state !== 2'd3 || lap_count !== CW'(3)) begin
            errors++; $display("FAIL pre_reset_recall got st=%0d cnt=%0d want 3 3", state, lap_count);
        end
        key_start = 1;
        @(negedge clk);
        key_start = 0;
        rst_n = 0;
        @(negedge clk);
        checks++; if (state !== 2'd0 || lap_count !== '0 || disp_out !== 24'h0) begin
            errors++; $display("FAIL reset_in_recall got st=%0d cnt=%0d disp=%h want 0 0 000000", state, lap_count, disp_out);
        end
        rst_n = 1;
        tick(6);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL pending_key_after_reset got st=%0d want=0", state); end
    endtask

    task automatic test_random();
        int shown = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++;
            if (state !== 2'(m_st) || disp_out !== m_disp || lap_count !== CW'(m_cnt) ||
                lap_full !== m_full || overflow !== m_ovf) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cyc%0d got st=%0d disp=%h cnt=%0d full=%b ovf=%b want st=%0d disp=%h cnt=%0d full=%b ovf=%b",
                             cyc, state, disp_out, lap_count, lap_full, overflow,
                             m_st, m_disp, m_cnt, m_full, m_ovf);
                end
            end
            rst_n      = ($urandom_range(0, 999) != 0);
            key_start  = ($urandom_range(0, 99) < 3);
            key_lap    = ($urandom_range(0, 99) < 8);
            key_recall = ($urandom_range(0, 99) < 8);
            tick(1);
        end
        rst_n = 1; key_start = 0; key_lap = 0; key_recall = 0;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_run_stop();
        test_overflow();
        test_lap_full();
        test_simultaneous();
        test_phase();
        test_reset_recall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
